// File: rtl/nnoc_pkg.sv
// Shared definitions for the byte-wide shift path: deserializer state
// encoding and the word width used by the shift-register chain.
package nnoc_pkg;

    localparam int unsigned WORD_WIDTH = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } deser_state_t;

endpackage

// File: rtl/word_deserializer.sv
// Packs LANES consecutive WIDTH-bit words into one output vector.
// A single holding register plus fill index gives full-rate streaming.
module word_deserializer
    import nnoc_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned WIDTH = WORD_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*WIDTH-1:0]     out_data,
    output logic [$clog2(LANES+1)-1:0] out_count
);

    localparam int unsigned IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned CW   = $clog2(LANES + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LANES - 1);

    deser_state_t            state_q;
    logic [IDXW-1:0]         idx_q;
    logic [LANES*WIDTH-1:0]  data_q;
    logic [CW-1:0]           count_q;
    logic                    valid_q;

    logic                    in_fire;
    logic [LANES*WIDTH-1:0]  restart_d;

    // out_ready -> in_ready is the only combinational path into in_ready.
    assign in_ready  = !reset && ((state_q == FILL) || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign restart_d = {{((LANES-1)*WIDTH){1'b0}}, in_data};

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_fire) begin
                        data_q[idx_q*WIDTH +: WIDTH] <= in_data;
                        if ((idx_q == LAST_IDX) || in_last) begin
                            state_q <= HOLD;
                            valid_q <= 1'b1;
                            count_q <= CW'(idx_q) + CW'(1);
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDXW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Handoff: new word starts the next vector in lane 0.
                            data_q <= restart_d;
                            if ((LANES == 1) || in_last) begin
                                count_q <= CW'(1);
                            end else begin
                                state_q <= FILL;
                                valid_q <= 1'b0;
                                idx_q   <= IDXW'(1);
                            end
                        end else begin
                            state_q <= FILL;
                            valid_q <= 1'b0;
                            data_q  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
